// File: rtl/ahb_mtx_dec_param.sv
// AHB bus-matrix input-port decoder.
// Steers one input stage to one of NUM_PORTS output stages by base/mask match
// (port 0 optionally remapped for boot), tracks the data-phase owner to mux the
// return path, and answers unmapped transfers with a built-in two-cycle ERROR
// slave whose hits are tallied in a saturating counter.
module ahb_mtx_dec_param #(
    parameter int                      NUM_PORTS  = 4,
    parameter logic [22*NUM_PORTS-1:0] ADDR_BASE  = {NUM_PORTS{22'h0}},
    parameter logic [22*NUM_PORTS-1:0] ADDR_MASK  = {NUM_PORTS{22'h3FFFC0}},
    parameter logic [21:0]             REMAP_BASE = 22'h000800
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [21:0]               decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic                      remap,
    input  logic                      err_clr,
    input  logic [NUM_PORTS-1:0]      active_in,
    input  logic [NUM_PORTS-1:0]      readyout_in,
    input  logic [2*NUM_PORTS-1:0]    resp_in,
    input  logic [32*NUM_PORTS-1:0]   rdata_in,
    input  logic [32*NUM_PORTS-1:0]   ruser_in,
    output logic [NUM_PORTS-1:0]      sel_out,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [31:0]               HRDATAS,
    output logic [31:0]               HRUSERS,
    output logic [15:0]               dec_err_cnt
);

    // Port index width; the extra code NUM_PORTS denotes the default slave.
    localparam int             PW  = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0]  DFT = PW'(NUM_PORTS);

    typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} dft_state_t;

    dft_state_t          r_state;
    logic                r_dft_ready;
    logic [1:0]          r_dft_resp;
    logic [PW-1:0]       r_data_port;
    logic [15:0]         r_err_cnt;

    logic [NUM_PORTS-1:0] w_hit;
    logic [PW-1:0]        w_addr_port;
    logic                 w_dft_req;
    logic                 w_err_inc;

    // Per-port base/mask hit; port 0 swaps in the boot remap base.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_hit
        logic [21:0] w_base;
        logic [21:0] w_mask;
        assign w_mask = ADDR_MASK[22*gi +: 22];
        if (gi == 0) begin : g_remap
            assign w_base = remap ? REMAP_BASE : ADDR_BASE[21:0];
        end else begin : g_fixed
            assign w_base = ADDR_BASE[22*gi +: 22];
        end
        assign w_hit[gi] = (decode_addr_dec & w_mask) == (w_base & w_mask);
    end

    // Lowest-index hit wins; IDLE keeps pointing at the current data-phase owner.
    always_comb begin
        w_addr_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) w_addr_port = PW'(i);
        end
        if (trans_dec == 2'b00 && r_data_port != DFT) w_addr_port = r_data_port;
    end

    // Address-phase select and active flag; default slave is always active.
    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_addr_port == PW'(i)) begin
                sel_out[i] = sel_dec;
                active_dec = active_in[i];
            end
        end
    end

    // Data-phase return mux keyed by the registered owner.
    always_comb begin
        HREADYOUTS = r_dft_ready;
        HRESPS     = r_dft_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_data_port == PW'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[32*i +: 32];
                HRUSERS    = ruser_in[32*i +: 32];
            end
        end
    end

    assign w_dft_req = sel_dec && (w_addr_port == DFT) && trans_dec[1];
    // ERR1 ignores HREADYS, so only a sampled request from OKAY/ERR2 counts.
    assign w_err_inc = (r_state != S_ERR1) && HREADYS && w_dft_req;

    // Data-phase owner advances when the input stage completes a transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     r_data_port <= '0;
        else if (HREADYS) r_data_port <= w_addr_port;
    end

    // Default slave: NONSEQ/SEQ gets (0,ERROR) then (1,ERROR); IDLE/BUSY zero-wait OKAY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_OKAY;
            r_dft_ready <= 1'b1;
            r_dft_resp  <= 2'b00;
        end else if (r_state == S_ERR1) begin
            r_state     <= S_ERR2;
            r_dft_ready <= 1'b1;
            r_dft_resp  <= 2'b01;
        end else if (HREADYS) begin
            if (w_dft_req) begin
                r_state     <= S_ERR1;
                r_dft_ready <= 1'b0;
                r_dft_resp  <= 2'b01;
            end else begin
                r_state     <= S_OKAY;
                r_dft_ready <= 1'b1;
                r_dft_resp  <= 2'b00;
            end
        end
    end

    // Saturating decode-error tally; clear beats a same-cycle increment.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                                r_err_cnt <= '0;
        else if (err_clr)                            r_err_cnt <= '0;
        else if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign dec_err_cnt = r_err_cnt;

endmodule

// File: doc/ahb_mtx_dec_param.md
# ahb_mtx_dec_param

Parametrised AHB bus-matrix input-port decoder for the system AHB matrix. It steers one input stage to one of NUM_PORTS output stages by per-port base/mask address match, with an optional boot remap of port 0. It tracks the data-phase owner and multiplexes the data-phase return signals. Unmapped addresses go to an integrated default slave that gives a two-cycle ERROR, and a saturating decode-error counter records each one.

## Interface
Parameters:
- NUM_PORTS, 4, number of output stages (1..8)
- ADDR_BASE, {NUM_PORTS{22'h0}}, packed 22-bit base per port, compared against HADDR[31:10]; port i in bits [22i+21:22i]
- ADDR_MASK, {NUM_PORTS{22'h3FFFC0}}, packed 22-bit mask per port, same packing
- REMAP_BASE, 22'h000800, port-0 base used while remap=1

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low
- HREADYS  in  1  input-stage HREADY (transfer done)
- sel_dec  in  1  input-stage HSEL
- decode_addr_dec  in  22  HADDR[31:10]
- trans_dec  in  2  HTRANS
- remap  in  1  port-0 remap enable, quasi-static
- err_clr  in  1  synchronous clear of dec_err_cnt
- active_in  in  NUM_PORTS  output-stage active flags
- readyout_in  in  NUM_PORTS  output-stage HREADYOUT
- resp_in  in  2*NUM_PORTS  output-stage HRESP
- rdata_in  in  32*NUM_PORTS  output-stage HRDATA
- ruser_in  in  32*NUM_PORTS  output-stage HRUSER
- sel_out  out  NUM_PORTS  one-hot HSEL to output stages
- active_dec  out  1  active flag of addressed stage
- HREADYOUTS  out  1  data-phase HREADYOUT
- HRESPS  out  2  data-phase HRESP (00 OKAY, 01 ERROR)
- HRDATAS  out  32  data-phase read data
- HRUSERS  out  32  data-phase user read data
- dec_err_cnt  out  16  saturating count of default-slave transfers

## Operation
- Hit test for port i: (decode_addr_dec & MASK[i]) == (BASE[i] & MASK[i]). For i=0 with remap=1, use REMAP_BASE as the base.
- Priority: the lowest-index hit wins. With no hit, addr_port = DFT, encoded as NUM_PORTS.
- Idle hold: if trans_dec==00 and data_port != DFT, then addr_port = data_port, regardless of address.
- sel_out[addr_port] = sel_dec. All other bits are 0. sel_out = 0 when addr_port = DFT.
- active_dec = active_in[addr_port]. It is 1 for DFT.
- data_port register:
  - Loads addr_port on each HCLK edge with HREADYS=1.
  - Holds otherwise.
  - Reset value 0.
- HREADYOUTS, HRESPS, HRDATAS and HRUSERS select the data_port entry. For DFT they come from the default slave, with rdata/ruser = 0.
- Default slave FSM, state advances only when HREADYS=1 or in ERR1:
  - OKAY: if sel_dec and addr_port=DFT and trans_dec[1]=1, go to ERR1. Otherwise stay, driving ready=1, resp=00.
  - ERR1: ready=0, resp=01. Always go to ERR2 next cycle.
  - ERR2: ready=1, resp=01. Return to OKAY, or go to ERR1 if a new qualifying transfer is sampled.
  - IDLE/BUSY to DFT: zero-wait OKAY.
- dec_err_cnt:
  - Increments on the edge entering ERR1.
  - Saturates at 16'hFFFF.
  - err_clr=1 forces 0 and wins over a simultaneous increment.

## Timing
- Reset (HRESETn low), effective immediately and asynchronously:
  - data_port=0, FSM=OKAY, dec_err_cnt=0.
  - HREADYOUTS=readyout_in[0], HRESPS=resp_in[1:0], HRDATAS=rdata_in[31:0], HRUSERS=ruser_in[31:0].
  - sel_out and active_dec remain combinational on their inputs.
- Address phase (sel_out, active_dec): combinational, zero latency.
- Data-phase muxing is registered by one HCLK through data_port.
- Default-slave error: exactly two data-phase cycles, (ready,resp) = (0,01) then (1,01).
- Reset asserted mid-ERR1: the FSM returns to OKAY and the next HREADYOUTS follows port 0.
- Changing remap during a data phase does not affect that data phase.

## Test plan
- Port hit: BASE1=22'h000040, MASK=22'h3FFFC0, addr[31:10]=22'h000050, NONSEQ, sel_dec=1 → sel_out=0010 same cycle. Next cycle HRDATAS=rdata_in[63:32].
- Overlap priority: ports 1 and 2 both match → sel_out=0010 only.
- Unmapped NONSEQ at 0xFFFF_0000 → HREADYOUTS 0 then 1, HRESPS 01 both cycles, HRDATAS=0, dec_err_cnt 0→1. IDLE to the same address → OKAY, zero wait, counter unchanged.
- Idle hold: NONSEQ to port 2, then IDLE with an unmapped address → sel_out[2] asserted, no ERROR.
- Remap: remap=1, address 22'h000800 → port 0 selected. remap=0 → default slave.
- Counter: preload to 16'hFFFF via 65535 errors, one more error → stays FFFF. err_clr together with an error → 0.
